// File: rtl/hnf_link_txrsp_pack_pkg.sv
// hnf_link_txrsp_pack_pkg
//   Shared definitions for the HN-F TXRSP link packer: CHI-E RSP flit field
//   widths and layout, RSP opcodes, the L-credit counter width, the credit
//   return FSM state encodings and the legal-opcode check.
//   No ports.
package hnf_link_txrsp_pack_pkg;

   localparam int RSP_QOS_W      = 4;
   localparam int RSP_NID_W      = 11;
   localparam int RSP_TXNID_W    = 12;
   localparam int RSP_OPCODE_W   = 5;
   localparam int RSP_RESPERR_W  = 2;
   localparam int RSP_RESP_W     = 3;
   localparam int RSP_FWDSTATE_W = 3;
   localparam int RSP_CBUSY_W    = 3;
   localparam int RSP_DBID_W     = 12;
   localparam int RSP_PCRDTYPE_W = 4;
   localparam int RSP_TAGOP_W    = 2;
   localparam int RSP_TRACETAG_W = 1;
   localparam int RSP_FLIT_W     = 73;

   localparam int LCRD_RSP_CNT_W = 4;

   // Field order is MSB first; QOS sits in the LSBs of the flit.
   typedef struct packed {
      logic [RSP_TRACETAG_W-1:0] tracetag;
      logic [RSP_TAGOP_W-1:0]    tagop;
      logic [RSP_PCRDTYPE_W-1:0] pcrdtype;
      logic [RSP_DBID_W-1:0]     dbid;
      logic [RSP_CBUSY_W-1:0]    cbusy;
      logic [RSP_FWDSTATE_W-1:0] fwdstate;
      logic [RSP_RESP_W-1:0]     resp;
      logic [RSP_RESPERR_W-1:0]  resperr;
      logic [RSP_OPCODE_W-1:0]   opcode;
      logic [RSP_TXNID_W-1:0]    txnid;
      logic [RSP_NID_W-1:0]      srcid;
      logic [RSP_NID_W-1:0]      tgtid;
      logic [RSP_QOS_W-1:0]      qos;
   } rsp_flit_t;

   localparam logic [RSP_OPCODE_W-1:0] CHIE_RSPLCRDRETURN = 5'h00;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_RETRYACK      = 5'h03;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_COMP          = 5'h04;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_COMPDBIDRESP  = 5'h05;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_DBIDRESP      = 5'h06;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_PCRDGRANT     = 5'h07;
   localparam logic [RSP_OPCODE_W-1:0] CHIE_READRECEIPT   = 5'h08;

   typedef enum logic [1:0] {
      HNF_TXRSP_ST_IDLE   = 2'd0,
      HNF_TXRSP_ST_RETURN = 2'd1,
      HNF_TXRSP_ST_DONE   = 2'd2
   } txrsp_st_e;

   // Opcodes the MSHR is allowed to hand to this packer.
   function automatic logic rsp_opcode_legal(input logic [RSP_OPCODE_W-1:0] opc);
      case (opc)
         CHIE_COMP, CHIE_DBIDRESP, CHIE_COMPDBIDRESP,
         CHIE_RETRYACK, CHIE_PCRDGRANT, CHIE_READRECEIPT: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hnf_link_txrsp_pack_lcrd_cnt.sv
// hnf_lcrd_cnt
//   Saturating up/down L-credit counter with a zero flag, shared by the
//   TXRSP/TXDAT/TXSNP packers.
//   clk, rst (async, active-high)
//   inc      : one credit granted this cycle
//   dec      : one credit consumed this cycle (only while cnt != 0)
//   cnt      : credits held
//   zero     : cnt == 0
//   sat_err  : grant arrived at MAX with no consume; the grant is dropped
module hnf_lcrd_cnt #(
   parameter int MAX = 15,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero,
   output logic         sat_err
);

   logic [W-1:0] cnt_nxt;

   assign zero    = (cnt == '0);
   assign sat_err = inc & ~dec & (cnt == W'(MAX));

   always_comb begin
      cnt_nxt = cnt;
      case ({inc, dec})
         2'b10:   if (!sat_err) cnt_nxt = cnt + 1'b1;
         2'b01:   if (!zero)    cnt_nxt = cnt - 1'b1;
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

endmodule

// File: rtl/hnf_link_txrsp_pack.sv
// hnf_link_txrsp_pack
//   HN-F TXRSP link layer: packs one MSHR response per cycle into a CHI-E RSP
//   flit, drives flitpend (s0) / flitv + flit (s1), and only sends while an
//   L-credit is held.
//   clk, rst (async, active-high)
//   txrsp_lcrdv                 : L-credit grant from the XP
//   txrspflitpend/flitv/flit    : link TX side, flit is zero when flitv=0
//   mshr_txrsp_*_s0             : response request and fields from the MSHR
//   txrsp_mshr_ready_s0         : request accepted when valid
//   txrsp_crd_cnt               : credits held
//   txrsp_crd_return_req/done   : only with HNF_TXRSP_LCRD_RETURN_EN; hands
//                                 every held credit back as RespLCrdReturn
//   DISPLAY_FATAL enables simulation stops on credit overflow / bad opcode.
module hnf_link_txrsp_pack
   import hnf_link_txrsp_pack_pkg::*;
#(
   parameter int HNF_NID_PARAM     = 0,
   parameter int XP_LCRD_NUM_PARAM = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      txrsp_lcrdv,
   output logic                      txrspflitpend,
   output logic                      txrspflitv,
   output logic [RSP_FLIT_W-1:0]     txrspflit,
   input  logic                      mshr_txrsp_valid_s0,
   input  logic [RSP_NID_W-1:0]      mshr_txrsp_tgtid_s0,
   input  logic [RSP_TXNID_W-1:0]    mshr_txrsp_txnid_s0,
   input  logic [RSP_OPCODE_W-1:0]   mshr_txrsp_opcode_s0,
   input  logic [RSP_RESP_W-1:0]     mshr_txrsp_resp_s0,
   input  logic [RSP_DBID_W-1:0]     mshr_txrsp_dbid_s0,
   input  logic [RSP_PCRDTYPE_W-1:0] mshr_txrsp_pcrdtype_s0,
   output logic                      txrsp_mshr_ready_s0,
   output logic [LCRD_RSP_CNT_W-1:0] txrsp_crd_cnt
`ifdef HNF_TXRSP_LCRD_RETURN_EN
   ,
   input  logic                      txrsp_crd_return_req,
   output logic                      txrsp_crd_return_done
`endif
);

   logic       crd_zero;
   logic       crd_sat_err;
   logic       accept_s0;
   logic       ret_send_s0;
   logic       send_s0;
   logic       opc_err;
   rsp_flit_t  flit_s0;

`ifdef HNF_TXRSP_LCRD_RETURN_EN
   txrsp_st_e  state, state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HNF_TXRSP_ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HNF_TXRSP_ST_IDLE:
            if (txrsp_crd_return_req) state_nxt = HNF_TXRSP_ST_RETURN;
         HNF_TXRSP_ST_RETURN:
            // Dropping req abandons the return; remaining credits stay usable.
            if (!txrsp_crd_return_req)         state_nxt = HNF_TXRSP_ST_IDLE;
            else if (crd_zero && !txrsp_lcrdv) state_nxt = HNF_TXRSP_ST_DONE;
         HNF_TXRSP_ST_DONE:
            if (!txrsp_crd_return_req) state_nxt = HNF_TXRSP_ST_IDLE;
            else if (txrsp_lcrdv)      state_nxt = HNF_TXRSP_ST_RETURN;
         default: state_nxt = HNF_TXRSP_ST_IDLE;
      endcase
   end

   always_comb begin
      // req blocks accepts combinationally in the cycle it first rises.
      txrsp_mshr_ready_s0   = ~crd_zero & (state == HNF_TXRSP_ST_IDLE) & ~txrsp_crd_return_req;
      ret_send_s0           = ~crd_zero & (state == HNF_TXRSP_ST_RETURN);
      txrsp_crd_return_done = (state == HNF_TXRSP_ST_DONE);
   end
`else
   assign txrsp_mshr_ready_s0 = ~crd_zero;
   assign ret_send_s0         = 1'b0;
`endif

   assign accept_s0     = mshr_txrsp_valid_s0 & txrsp_mshr_ready_s0;
   assign send_s0       = accept_s0 | ret_send_s0;
   assign txrspflitpend = send_s0;
   assign opc_err       = mshr_txrsp_valid_s0 & ~rsp_opcode_legal(mshr_txrsp_opcode_s0);

   // Accept and credit return are mutually exclusive (accept needs IDLE).
   always_comb begin
      flit_s0       = '0;
      flit_s0.srcid = RSP_NID_W'(HNF_NID_PARAM);
      if (ret_send_s0) begin
         flit_s0.opcode = CHIE_RSPLCRDRETURN;
      end else begin
         flit_s0.tgtid    = mshr_txrsp_tgtid_s0;
         flit_s0.txnid    = mshr_txrsp_txnid_s0;
         flit_s0.opcode   = mshr_txrsp_opcode_s0;
         flit_s0.resp     = mshr_txrsp_resp_s0;
         flit_s0.dbid     = mshr_txrsp_dbid_s0;
         flit_s0.pcrdtype = mshr_txrsp_pcrdtype_s0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txrspflitv <= 1'b0;
         txrspflit  <= '0;
      end else begin
         txrspflitv <= send_s0;
         txrspflit  <= send_s0 ? flit_s0 : '0;
      end
   end

   // Registered count means a grant is only usable the cycle after it lands.
   hnf_lcrd_cnt #(
      .MAX (XP_LCRD_NUM_PARAM),
      .W   (LCRD_RSP_CNT_W)
   ) u_crd (
      .clk     (clk),
      .rst     (rst),
      .inc     (txrsp_lcrdv),
      .dec     (send_s0),
      .cnt     (txrsp_crd_cnt),
      .zero    (crd_zero),
      .sat_err (crd_sat_err)
   );

`ifdef DISPLAY_FATAL
   always_ff @(posedge clk) begin
      if (!rst && crd_sat_err) $fatal(1, "hnf_link_txrsp_pack: L-credit grant beyond max");
      if (!rst && opc_err)     $fatal(1, "hnf_link_txrsp_pack: unsupported RSP opcode %0h", mshr_txrsp_opcode_s0);
   end
`endif

endmodule

// File: tb/tb_hnf_link_txrsp_pack.sv
module tb_hnf_link_txrsp_pack;

   localparam int NID = 'h25;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lcrdv = 1'b0;
   logic        flitpend, flitv;
   logic [72:0] flit;
   logic        vld = 1'b0;
   logic [10:0] tgt = '0;
   logic [11:0] txn = '0;
   logic [4:0]  opc = '0;
   logic [2:0]  resp = '0;
   logic [11:0] dbid = '0;
   logic [3:0]  pcrd = '0;
   logic        ready;
   logic [3:0]  crd_cnt;
   logic        req = 1'b0;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct { logic v; logic [72:0] f; } exp_t;
   exp_t q[$];

   int cnt_m = 0;
   int st_m  = 0;   // 0 idle, 1 return, 2 done

   always #5 clk = ~clk;

   hnf_link_txrsp_pack #(.HNF_NID_PARAM(NID), .XP_LCRD_NUM_PARAM(15)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .txrsp_lcrdv            (lcrdv),
      .txrspflitpend          (flitpend),
      .txrspflitv             (flitv),
      .txrspflit              (flit),
      .mshr_txrsp_valid_s0    (vld),
      .mshr_txrsp_tgtid_s0    (tgt),
      .mshr_txrsp_txnid_s0    (txn),
      .mshr_txrsp_opcode_s0   (opc),
      .mshr_txrsp_resp_s0     (resp),
      .mshr_txrsp_dbid_s0     (dbid),
      .mshr_txrsp_pcrdtype_s0 (pcrd),
      .txrsp_mshr_ready_s0    (ready),
      .txrsp_crd_cnt          (crd_cnt)
`ifdef HNF_TXRSP_LCRD_RETURN_EN
      ,
      .txrsp_crd_return_req   (req),
      .txrsp_crd_return_done  (done)
`endif
   );

`ifndef HNF_TXRSP_LCRD_RETURN_EN
   assign done = 1'b0;
`endif

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // CHI-E RSP layout, LSB first: QOS4 TGTID11 SRCID11 TXNID12 OPCODE5 RESPERR2
   // RESP3 FWDSTATE3 CBUSY3 DBID12 PCRDTYPE4 TAGOP2 TRACETAG1.
   function automatic logic [72:0] mk_flit(input logic [10:0] t, input logic [11:0] x,
                                           input logic [4:0] o, input logic [2:0] r,
                                           input logic [11:0] d, input logic [3:0] p);
      logic [10:0] s;
      s = 11'(NID);
      return {1'b0, 2'b0, p, d, 3'b0, 3'b0, r, 2'b0, o, x, s, t, 4'b0};
   endfunction

   // Flit output monitor: each step pushes what must appear one cycle later.
   always @(negedge clk) begin
      if (!rst && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("flitv", flitv, e.v);
         chk("flit", flit, e.f);
      end
   end

   task automatic step(input logic g, input logic v, input logic [4:0] o,
                       input logic [10:0] t, input logic [11:0] x,
                       input logic [2:0] r, input logic [11:0] d, input logic [3:0] p,
                       input logic rq);
      logic rdy_m, acc_m, ret_m, snd_m;
      exp_t e;
      int   c0;
      @(negedge clk);
      lcrdv = g; vld = v; opc = o; tgt = t; txn = x; resp = r; dbid = d; pcrd = p; req = rq;
      #1;
`ifdef HNF_TXRSP_LCRD_RETURN_EN
      rdy_m = (cnt_m != 0) && (st_m == 0) && !rq;
      ret_m = (st_m == 1) && (cnt_m != 0);
      chk("done", done, st_m == 2);
`else
      rdy_m = (cnt_m != 0);
      ret_m = 1'b0;
`endif
      acc_m = v && rdy_m;
      snd_m = acc_m || ret_m;
      chk("ready", ready, rdy_m);
      chk("pend", flitpend, snd_m);
      chk("crd_cnt", crd_cnt, cnt_m);
      e.v = snd_m;
      e.f = !snd_m ? '0 : ret_m ? mk_flit('0, '0, 5'h00, '0, '0, '0) : mk_flit(t, x, o, r, d, p);
      q.push_back(e);
      c0 = cnt_m;
      if (g && !snd_m && cnt_m == 15) chk("sat_err", dut.u_crd.sat_err, 1'b1);
      cnt_m = cnt_m + (g ? 1 : 0) - (snd_m ? 1 : 0);
      if (cnt_m > 15) cnt_m = 15;
`ifdef HNF_TXRSP_LCRD_RETURN_EN
      case (st_m)
         0: if (rq) st_m = 1;
         1: if (!rq) st_m = 0; else if (c0 == 0 && !g) st_m = 2;
         default: if (!rq) st_m = 0; else if (g) st_m = 1;
      endcase
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, req);
   endtask

   task automatic grant(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, req);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      lcrdv = 0; vld = 0; req = 0;
      q.delete();
      cnt_m = 0; st_m = 0;
      #1;
      chk("rst_flitv", flitv, 1'b0);
      chk("rst_flit", flit, '0);
      chk("rst_pend", flitpend, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_cnt", crd_cnt, '0);
      chk("rst_done", done, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      // 1: three grants, then Comp; cnt 3 -> 2, flit one cycle after pend.
      do_reset();
      grant(3);
      step(0, 1, 5'h04, 11'h4, 12'h12, 3'h0, 12'h0, 4'h0, 0);
      idle(1);
      // Back-to-back accepts draining the last two credits.
      step(0, 1, 5'h06, 11'h7, 12'h3a, 3'h0, 12'h5c, 4'h0, 0);
      step(0, 1, 5'h05, 11'h1ff, 12'hfff, 3'h2, 12'habc, 4'h0, 0);
      // 2: no credits with valid held; grant in N gives ready in N+1.
      step(0, 1, 5'h08, 11'h9, 12'h44, 3'h0, 12'h0, 4'h0, 0);
      step(1, 1, 5'h08, 11'h9, 12'h44, 3'h0, 12'h0, 4'h0, 0);
      step(0, 1, 5'h08, 11'h9, 12'h44, 3'h0, 12'h0, 4'h0, 0);
      // Valid dropped without ready, then idle.
      step(0, 0, 5'h04, 11'h1, 12'h1, 3'h0, 12'h0, 4'h0, 0);
      // 3: grant+accept together keeps cnt; consecutive flits.
      grant(1);
      step(1, 1, 5'h03, 11'h2, 12'h10, 3'h0, 12'h0, 4'hb, 0);
      step(0, 1, 5'h07, 11'h3, 12'h11, 3'h0, 12'h0, 4'h5, 0);
      idle(1);
      // 4: saturate at 15, a 16th grant is dropped and flagged.
      grant(15);
      grant(1);
      idle(1);
      // Random traffic mix.
      for (int i = 0; i < 30; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), 5'h04 + 5'($urandom_range(0, 4)),
              11'($urandom), 12'($urandom), 3'($urandom), 12'($urandom), 4'($urandom), 0);
      idle(1);
      // Reset in the middle of traffic.
      step(0, 1, 5'h04, 11'h5, 12'h55, 3'h0, 12'h0, 4'h0, 0);
      do_reset();
      idle(1);
`ifdef HNF_TXRSP_LCRD_RETURN_EN
      // 5: return four credits with MSHR valid held; then done, drop req.
      grant(4);
      for (int i = 0; i < 7; i++) step(0, 1, 5'h04, 11'h6, 12'h66, 3'h0, 12'h0, 4'h0, 1);
      step(0, 1, 5'h04, 11'h6, 12'h66, 3'h0, 12'h0, 4'h0, 0);
      grant(1);
      step(0, 1, 5'h04, 11'h6, 12'h66, 3'h0, 12'h0, 4'h0, 0);
      // Grant during DONE re-enters RETURN.
      grant(2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // 6: reset mid-RETURN with cnt=2, then IDLE behaviour resumes.
      grant(4);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      do_reset();
      grant(1);
      step(0, 1, 5'h04, 11'h8, 12'h88, 3'h0, 12'h0, 4'h0, 0);
`endif
      idle(1);
      repeat (2) @(negedge clk);
      chk("q_drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
